uart_rx_fifo: RTL

Parametrised UART receiver with an output FIFO, for the iCE40 debug link. It samples `RX` at 16x the baud rate and rejects glitched start bits. It checks the stop bit, and optionally parity, then pushes good characters into a show-ahead FIFO drained through a valid/ready handshake. It replaces the fixed 8N1, single-register receiver that feeds the transmit path and the LED taps.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states, oversampling
// constants and the baud divisor calculation.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int baud_div(input int clk_hz, input int baud);
        int div;
        div = (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == ptr_t'(DEPTH));
    assign empty_o = (level_o == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign wr_ptr_d = wr_ptr_q + ptr_t'(do_push);
    assign rd_ptr_d = rd_ptr_q + ptr_t'(do_pop);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a show-ahead FIFO. Defining
// UART_RX_PARITY_EN adds a parity bit after the data bits.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          iCE_CLK,
    input  logic                          RST,
    input  logic                          RX,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    typedef logic [DIV_W-1:0] div_t;
    typedef logic [BIT_W-1:0] bit_t;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e            state_q, state_d;
    div_t                 div_cnt_q, div_cnt_d;
    logic [3:0]           cnt_q, cnt_d;
    bit_t                 bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_d;
    logic                 overflow_q, overflow_d;
    logic                 tick, mid_bit, end_bit, fall, realign, push, parity_ok;
    logic                 fifo_full, fifo_empty;

    always_ff @(posedge iCE_CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A bit is sampled on the tick that brings the count to SAMPLE_POINT.
    assign tick    = (div_cnt_q == div_t'(DIV - 1));
    assign mid_bit = tick && (cnt_q == 4'(SAMPLE_POINT - 1));
    assign end_bit = tick && (cnt_q == 4'(OVERSAMPLE - 1));
    assign fall    = rx_prev_q && !rx_sync_q;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q;

    assign parity_ok  = (par_q == (^shift_q ^ 1'(PARITY_ODD)));
    assign parity_err = parity_err_q;

    always_ff @(posedge iCE_CLK or posedge RST) begin
        if (RST) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
`else
    // PARITY_ODD only matters when the parity state is built.
    logic unused_parity_odd;
    assign unused_parity_odd = 1'(PARITY_ODD);
    assign parity_ok         = 1'b1;
    assign parity_err        = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        realign      = 1'b0;
        push         = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    realign = 1'b1;
                end
            end
            ST_START: begin
                if (mid_bit && rx_sync_q) begin
                    state_d = ST_IDLE;
                end else if (end_bit) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (mid_bit) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                end
                if (end_bit) begin
                    if (bit_cnt_q == bit_t'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + bit_t'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_bit) begin
                    par_d = rx_sync_q;
                end
                if (end_bit) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (mid_bit) begin
                    if (!rx_sync_q) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else begin
                        push         = parity_ok;
                        parity_err_d = !parity_ok;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        div_cnt_d  = (realign || tick) ? '0 : div_cnt_q + div_t'(1);
        overflow_d = push && fifo_full && !rd_ready;
    end

    always_ff @(posedge iCE_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (iCE_CLK),
        .rst_i   (RST),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_ready),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rd_valid  = !fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule
